// File: rtl/merge2_rr_pkg.sv
// rtl/merge2_rr_pkg.sv - shared constants for the two-input round-robin merge
package merge2_rr_pkg;

    localparam logic SRC_IN0 = 1'b0;
    localparam logic SRC_IN1 = 1'b1;

endpackage

// File: rtl/merge2_rr_if.sv
// rtl/merge2_rr_if.sv - producer/consumer handshake bundle around merge2_rr
interface merge2_rr_if #(
    parameter int nbits = 8
);
    logic             in0_val;
    logic             in0_rdy;
    logic [nbits-1:0] in0_msg;
    logic             in1_val;
    logic             in1_rdy;
    logic [nbits-1:0] in1_msg;
    logic             out_val;
    logic             out_rdy;
    logic [nbits-1:0] out_msg;
    logic             out_src;

    modport slave (
        input  in0_val, in0_msg, in1_val, in1_msg, out_rdy,
        output in0_rdy, in1_rdy, out_val, out_msg, out_src
    );

    modport master (
        output in0_val, in0_msg, in1_val, in1_msg, out_rdy,
        input  in0_rdy, in1_rdy, out_val, out_msg, out_src
    );
endinterface

// File: rtl/merge2_rr_arb.sv
// rtl/merge2_rr_arb.sv - two-way round-robin arbiter with a one-bit priority pointer
module merge2_rr_arb
    import merge2_rr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in0_val,
    input  logic in1_val,
    input  logic acc_en,
    output logic grant0,
    output logic grant1
);

    logic prio;

    // prio only breaks ties; a lone requester always wins
    always_comb begin
        grant0 = in0_val & (~in1_val | (prio == SRC_IN0));
        grant1 = in1_val & (~in0_val | (prio == SRC_IN1));
    end

    // the port just served becomes least favoured
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= SRC_IN0;
        end else if (acc_en) begin
            prio <= grant1 ? SRC_IN0 : SRC_IN1;
        end
    end

endmodule

// File: rtl/merge2_rr.sv
// rtl/merge2_rr.sv - round-robin merge of two val/rdy streams into a one-entry output buffer
module merge2_rr
    import merge2_rr_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic           clk,
    input  logic           rst,
    merge2_rr_if.slave     bus
);

    logic             grant0;
    logic             grant1;
    logic             can_acc;
    logic             accept;
    logic [nbits-1:0] mux_out;
    logic             out_val_q;
    logic [nbits-1:0] out_msg_q;
    logic             out_src_q;

    merge2_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .in0_val (bus.in0_val),
        .in1_val (bus.in1_val),
        .acc_en  (accept),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    // a draining entry frees the slot in the same cycle for full throughput
    assign can_acc = ~out_val_q | bus.out_rdy;
    assign accept  = can_acc & (grant0 | grant1) & ~rst;

    assign bus.in0_rdy = can_acc & grant0 & ~rst;
    assign bus.in1_rdy = can_acc & grant1 & ~rst;

    assign mux_out = grant1 ? bus.in1_msg : bus.in0_msg;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_val_q <= 1'b0;
            out_msg_q <= '0;
            out_src_q <= SRC_IN0;
        end else if (accept) begin
            out_val_q <= 1'b1;
            out_msg_q <= mux_out;
            out_src_q <= grant1;
        end else if (bus.out_rdy) begin
            out_val_q <= 1'b0;
        end
    end

    assign bus.out_val = out_val_q;
    assign bus.out_msg = out_msg_q;
    assign bus.out_src = out_src_q;

endmodule

// File: doc/merge2_rr.md
Name: merge2_rr

Overview:
- Two-input round-robin stream merge with a one-entry registered output buffer.
- Two latency-insensitive val/rdy producers feed it. A small arbiter picks one per cycle and drives the select of an nbits-wide 2-to-1 datapath mux.
- The mux output is captured into an output register that a single downstream consumer drains.
- Sits directly downstream of the 2-to-1 mux: it generates the mux select and consumes the mux output.

Parameters:
- nbits, 8, width of every message port and the output register.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in0_val  input  1  port 0 message valid
- in0_rdy  output  1  port 0 message accepted this cycle when in0_val & in0_rdy
- in0_msg  input  nbits  port 0 message
- in1_val  input  1  port 1 message valid
- in1_rdy  output  1  port 1 message accepted this cycle when in1_val & in1_rdy
- in1_msg  input  nbits  port 1 message
- out_val  output  1  output register holds a message
- out_rdy  input  1  consumer accepts when out_val & out_rdy
- out_msg  output  nbits  buffered message
- out_src  output  1  source port of buffered message (0 = in0, 1 = in1)

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is rst. When rst=1 at a rising edge: out_val=0, out_msg=0, out_src=0, prio=0 (in0 favoured). rst overrides any simultaneous transfer; a message held mid-handshake is dropped.
- State:
  - out_val, out_msg, out_src registers.
  - prio, a 1-bit round-robin pointer naming the favoured port.
- can_acc = ~out_val | out_rdy. A buffered message draining this cycle frees the slot for a same-cycle accept, giving full throughput of 1 message/cycle.
- Grant (combinational):
  - Only in0_val: grant0.
  - Only in1_val: grant1.
  - Both valid: grant the port named by prio.
  - Neither valid: no grant.
- in0_rdy = can_acc & grant0; in1_rdy = can_acc & grant1.
  - rdy may depend on val; producers must not make val depend on rdy.
  - At most one rdy is high in any cycle.
- Mux select = grant1; mux output feeds the out_msg register input.
- On accept (can_acc & any grant), at the next edge:
  - out_msg <= selected msg, out_src <= grant1, out_val <= 1.
  - prio <= ~granted port, i.e. the just-served port becomes least-favoured.
- Drain without accept (out_val & out_rdy, no grant): out_val <= 0. out_msg and out_src hold their stale value.
- Stall (out_val & ~out_rdy):
  - Both in*_rdy are 0.
  - out_msg, out_src and prio hold.
  - out_val stays 1.
- prio changes only on an accept, never on idle or stall cycles.
- Latency: an input accepted at edge N appears on out_val/out_msg after edge N (1 cycle).
- No message is ever dropped or duplicated outside of reset.

Decomposition:
- Shared header with localparams SRC_IN0=1'b0 and SRC_IN1=1'b1, used by this block and its test bench.
- One natural sub-module: merge2_rr_arb.
  - Contents: prio flop, grant logic, prio update.
  - Inputs: clk, rst, in0_val, in1_val, acc_en.
  - Outputs: grant0, grant1.
- Datapath uses the team's existing nbits-wide 2-to-1 mux plus a reset/enable register.

Test Plan:
- Reset: assert rst 2 cycles with in0_val=in1_val=1 -> out_val=0, out_msg=0, out_src=0, both rdy=0 during reset. The first post-reset grant goes to in0.
- Single port: in0 sends 0x11, 0x22, 0x33 back-to-back with out_rdy=1 and in1 idle -> in0_rdy=1 every cycle. out_msg=0x11, 0x22, 0x33 on consecutive cycles, out_src=0, one cycle after each accept.
- Contention: in0 streams 0xA0.., in1 streams 0xB0.., both always valid, out_rdy=1 -> outputs alternate 0xA0, 0xB0, 0xA1, 0xB1 with out_src 0, 1, 0, 1.
- Backpressure: out_val=1 holding 0x5A, out_rdy=0 for 3 cycles, both inputs valid -> both rdy=0, out_msg stays 0x5A, prio unchanged. On out_rdy=1, drain and accept occur in the same cycle.
- Fairness after idle: in1 alone sends 0x01, then idle 2 cycles, then both valid -> in0 granted first, because prio was updated only by the accept.
- Reset mid-stream: rst=1 while out_val=1, out_rdy=0 -> next cycle out_val=0, prio=0. The held message is never delivered.
